// File: rtl/uint16_segment_reader_if.sv
// Display-scan bus plus scan request/result signals of the UInt16 segment reader.
// The reader uses the slave modport; the display/host side uses master.
interface uint16_segment_reader_if;
  logic        start;
  logic        top_left;
  logic        top;
  logic        top_right;
  logic        bottom_right;
  logic        bottom;
  logic        bottom_left;
  logic        middle;
  logic [4:0]  digit_sel;
  logic        busy;
  logic [15:0] value;
  logic        valid;
  logic        error;

  modport master (
    output start, top_left, top, top_right, bottom_right, bottom, bottom_left, middle,
    input  digit_sel, busy, value, valid, error
  );

  modport slave (
    input  start, top_left, top, top_right, bottom_right, bottom, bottom_left, middle,
    output digit_sel, busy, value, valid, error
  );
endinterface

// File: rtl/uint16_segment_reader.sv
// Scans a five-digit multiplexed seven-segment display and rebuilds the UInt16 it shows.
// Define UINT16_READER_CONTINUOUS_EN to repeat scans back-to-back without start.
//
// state    | meaning
// IDLE     | no scan, digit_sel=0, waits for start
// SETTLE   | digit selected, counting SETTLE_CYCLES before sampling
// SAMPLE   | segments decoded and accumulated for the current position
// DONE     | one cycle, valid or error pulse, value updated on success
module uint16_segment_reader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uint16_segment_reader_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [2:0]  pos;
  logic [7:0]  settle_cnt;
  logic [16:0] acc;
  logic        seen_digit;
  logic [15:0] value_q;
  logic        valid_q;
  logic        error_q;

  logic [6:0]  seg;
  logic        is_digit;
  logic [3:0]  digit;
  logic        blank;
  logic [16:0] acc_next;
  logic        sample_fail;

  // seg is a..g: top, top_right, bottom_right, bottom, bottom_left, top_left, middle
  assign seg = {bus.top, bus.top_right, bus.bottom_right, bus.bottom,
                bus.bottom_left, bus.top_left, bus.middle};

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (seg)
      7'b1111110: digit = 4'd0;
      7'b0110000: digit = 4'd1;
      7'b1101101: digit = 4'd2;
      7'b1111001: digit = 4'd3;
      7'b0110011: digit = 4'd4;
      7'b1011011: digit = 4'd5;
      7'b1011111: digit = 4'd6;
      7'b1110000: digit = 4'd7;
      7'b1111111: digit = 4'd8;
      7'b1111011: digit = 4'd9;
      default:    is_digit = 1'b0;
    endcase
  end

  assign blank    = (seg == 7'd0);
  assign acc_next = acc * 17'd10 + {13'd0, digit};

  // Leading blanks are legal; a blank after a digit, a garbage pattern, overflow,
  // or an entirely blank display all fail the scan.
  assign sample_fail = (!is_digit && (!blank || seen_digit))
                     || (is_digit && (acc_next > 17'd65535))
                     || ((pos == 3'd0) && blank && !seen_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pos        <= 3'd0;
      settle_cnt <= 8'd0;
      acc        <= 17'd0;
      seen_digit <= 1'b0;
      value_q    <= 16'd0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_SETTLE;
            pos        <= 3'd4;
            settle_cnt <= SETTLE_LOAD;
            acc        <= 17'd0;
            seen_digit <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) state <= S_SAMPLE;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        S_SAMPLE: begin
          if (is_digit) begin
            acc        <= acc_next;
            seen_digit <= 1'b1;
          end
          if (sample_fail) begin
            state   <= S_DONE;
            error_q <= 1'b1;
          end else if (pos == 3'd0) begin
            state   <= S_DONE;
            valid_q <= 1'b1;
            value_q <= is_digit ? acc_next[15:0] : acc[15:0];
          end else begin
            pos        <= pos - 3'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end
        S_DONE: begin
`ifdef UINT16_READER_CONTINUOUS_EN
          state      <= S_SETTLE;
          pos        <= 3'd4;
          settle_cnt <= SETTLE_LOAD;
          acc        <= 17'd0;
          seen_digit <= 1'b0;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.digit_sel = ((state == S_SETTLE) || (state == S_SAMPLE)) ? (5'b00001 << pos) : 5'b00000;
  assign bus.busy      = (state != S_IDLE);
  assign bus.value     = value_q;
  assign bus.valid     = valid_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_uint16_segment_reader.sv
// Directed bench for uint16_segment_reader with a behavioural multiplexed display model.
module tb_uint16_segment_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uint16_segment_reader_if bus();
  uint16_segment_reader #(.SETTLE_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] disp [5];
  logic [6:0] seg;

  always_comb begin
    seg = 7'd0;
    for (int i = 0; i < 5; i++)
      if (bus.digit_sel[i]) seg = disp[i];
  end

  assign bus.top          = seg[6];
  assign bus.top_right    = seg[5];
  assign bus.bottom_right = seg[4];
  assign bus.bottom       = seg[3];
  assign bus.bottom_left  = seg[2];
  assign bus.top_left     = seg[1];
  assign bus.middle       = seg[0];

  // 10 = blank, 11 = top segment only
  function automatic logic [6:0] pat(int d);
    case (d)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
      11: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic set_disp(int d4, int d3, int d2, int d1, int d0);
    disp[4] = pat(d4);
    disp[3] = pat(d3);
    disp[2] = pat(d2);
    disp[1] = pat(d1);
    disp[0] = pat(d0);
  endtask

  // Pulse start and wait (bounded) for valid or error; n counts edges from the start-capturing edge.
  task automatic run_scan(output int n, output logic v, output logic e, output logic [4:0] sel_mask);
    @(negedge clk);
    bus.start = 1'b1;
    n = 40; v = 1'b0; e = 1'b0; sel_mask = 5'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      sel_mask = sel_mask | bus.digit_sel;
      if (bus.valid || bus.error) begin
        n = k; v = bus.valid; e = bus.error;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    set_disp(10, 10, 10, 10, 10);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.digit_sel !== 5'd0) begin n_bad++; $display("FAIL reset_digit_sel got %b exp 00000", bus.digit_sel); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.value !== 16'd0) begin n_bad++; $display("FAIL reset_value got %h exp 0000", bus.value); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b exp 0", bus.error); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifndef UINT16_READER_CONTINUOUS_EN
  task automatic test_full_scale();
    logic [4:0] exp_sel;
    set_disp(6, 5, 5, 3, 5);
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if ((k % 3 == 1) && (k < 15)) begin
        exp_sel = 5'b10000 >> (k / 3);
        n_cmp++; if (bus.digit_sel !== exp_sel) begin n_bad++; $display("FAIL walk_sel k=%0d got %b exp %b", k, bus.digit_sel, exp_sel); end
      end
      if (k == 14) begin
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL early_valid got %b exp 0", bus.valid); end
      end
    end
    n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got %b exp 1", bus.valid); end
    n_cmp++; if (bus.value !== 16'hFFFF) begin n_bad++; $display("FAIL full_value got %h exp ffff", bus.value); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL full_error got %b exp 0", bus.error); end
    n_cmp++; if (bus.digit_sel !== 5'd0) begin n_bad++; $display("FAIL done_sel got %b exp 00000", bus.digit_sel); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL done_busy got %b exp 1", bus.busy); end
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL valid_width got %b exp 0", bus.valid); end
  endtask

  task automatic test_all_blank();
    int n; logic v, e; logic [4:0] m;
    set_disp(10, 10, 10, 10, 10);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL blank_latency got %0d exp 16", n); end
    n_cmp++; if ({v, e} !== 2'b01) begin n_bad++; $display("FAIL blank_flags got %b exp 01", {v, e}); end
    n_cmp++; if (bus.value !== 16'hFFFF) begin n_bad++; $display("FAIL blank_value got %h exp ffff", bus.value); end
  endtask

  task automatic test_leading_blanks();
    int n; logic v, e; logic [4:0] m;
    set_disp(10, 10, 4, 0, 7);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL lead_latency got %0d exp 16", n); end
    n_cmp++; if ({v, e} !== 2'b10) begin n_bad++; $display("FAIL lead_flags got %b exp 10", {v, e}); end
    n_cmp++; if (bus.value !== 16'd407) begin n_bad++; $display("FAIL lead_value got %0d exp 407", bus.value); end
  endtask

  task automatic test_overflow();
    int n; logic v, e; logic [4:0] m;
    set_disp(6, 5, 5, 3, 6);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL ovf65536_latency got %0d exp 16", n); end
    n_cmp++; if ({v, e} !== 2'b01) begin n_bad++; $display("FAIL ovf65536_flags got %b exp 01", {v, e}); end
    n_cmp++; if (bus.value !== 16'd407) begin n_bad++; $display("FAIL ovf65536_value got %0d exp 407", bus.value); end
    set_disp(9, 9, 9, 9, 9);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL ovf99999_latency got %0d exp 16", n); end
    n_cmp++; if ({v, e} !== 2'b01) begin n_bad++; $display("FAIL ovf99999_flags got %b exp 01", {v, e}); end
    n_cmp++; if (bus.value !== 16'd407) begin n_bad++; $display("FAIL ovf99999_value got %0d exp 407", bus.value); end
  endtask

  task automatic test_invalid_pattern();
    int n; logic v, e; logic [4:0] m;
    set_disp(1, 2, 11, 4, 5);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL invalid_latency got %0d exp 10", n); end
    n_cmp++; if ({v, e} !== 2'b01) begin n_bad++; $display("FAIL invalid_flags got %b exp 01", {v, e}); end
    n_cmp++; if (m !== 5'b11100) begin n_bad++; $display("FAIL invalid_sel_seen got %b exp 11100", m); end
  endtask

  task automatic test_interior_blank();
    int n; logic v, e; logic [4:0] m;
    set_disp(1, 10, 2, 10, 3);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL interior_latency got %0d exp 7", n); end
    n_cmp++; if ({v, e} !== 2'b01) begin n_bad++; $display("FAIL interior_flags got %b exp 01", {v, e}); end
    n_cmp++; if (bus.value !== 16'd407) begin n_bad++; $display("FAIL interior_value got %0d exp 407", bus.value); end
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    set_disp(1, 2, 3, 4, 5);
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.digit_sel == 5'b00100) break;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.digit_sel, bus.busy, bus.valid, bus.error} !== 8'd0) begin n_bad++; $display("FAIL midrst_ctrl got %b exp 00000000", {bus.digit_sel, bus.busy, bus.valid, bus.error}); end
    n_cmp++; if (bus.value !== 16'd0) begin n_bad++; $display("FAIL midrst_value got %0d exp 0", bus.value); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.error) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_pulses got %0d exp 0", pulses); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_start_while_busy();
    int vcount, ecount;
    logic busy16;
    set_disp(10, 10, 4, 0, 7);
    vcount = 0; ecount = 0; busy16 = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.valid) vcount++;
      if (bus.error) ecount++;
      if (k == 16) busy16 = bus.busy;
      if (k == 5 || k == 15) bus.start = 1'b1;
    end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL busy_start_valids got %0d exp 1", vcount); end
    n_cmp++; if (ecount !== 0) begin n_bad++; $display("FAIL busy_start_errors got %0d exp 0", ecount); end
    n_cmp++; if (busy16 !== 1'b0) begin n_bad++; $display("FAIL busy_start_restart got %b exp 0", busy16); end
    n_cmp++; if (bus.value !== 16'd407) begin n_bad++; $display("FAIL busy_start_value got %0d exp 407", bus.value); end
  endtask

  task automatic test_single_zero();
    int n; logic v, e; logic [4:0] m;
    set_disp(10, 10, 10, 10, 0);
    run_scan(n, v, e, m);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL zero_latency got %0d exp 16", n); end
    n_cmp++; if ({v, e} !== 2'b10) begin n_bad++; $display("FAIL zero_flags got %b exp 10", {v, e}); end
    n_cmp++; if (bus.value !== 16'd0) begin n_bad++; $display("FAIL zero_value got %0d exp 0", bus.value); end
  endtask
`else
  task automatic test_continuous();
    int n;
    logic v, e;
    set_disp(10, 10, 1, 0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    v = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.valid || bus.error) begin v = bus.valid; break; end
    end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL cont_first_valid got %b exp 1", v); end
    n_cmp++; if (bus.value !== 16'd100) begin n_bad++; $display("FAIL cont_first_value got %0d exp 100", bus.value); end
    set_disp(10, 10, 2, 0, 0);
    n = 40; v = 1'b0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.error) begin n = k; v = bus.valid; e = bus.error; break; end
    end
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL cont_period got %0d exp 16", n); end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL cont_second_valid got %b exp 1", v); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL cont_second_error got %b exp 0", e); end
    n_cmp++; if (bus.value !== 16'd200) begin n_bad++; $display("FAIL cont_second_value got %0d exp 200", bus.value); end
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy got %b exp 1", bus.busy); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    test_reset();
`ifndef UINT16_READER_CONTINUOUS_EN
    test_full_scale();
    test_all_blank();
    test_leading_blanks();
    test_overflow();
    test_invalid_pattern();
    test_interior_blank();
    test_reset_mid_scan();
    test_start_while_busy();
    test_single_zero();
`else
    test_continuous();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
